// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch unit: one outstanding IMEM request at a time,
// {pc, inst} delivered downstream over valid/ready, with redirect and halt.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               drop_q, drop_d;
  logic               halt_pend_q, halt_pend_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        redir_pc;
  logic               drop_now;
  logic               halt_now;
  logic               unused_redirect_lsbs;

  assign redir_pc             = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      inst_q      <= 32'h0;
      inst_pc_q   <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      halt_pend_q <= halt_pend_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    halt_pend_d = halt_pend_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    cnt_d       = cnt_q;
    drop_now    = 1'b0;
    halt_now    = 1'b0;

    // Redirect loads the PC in any state; halt takes priority over it.
    if (redirect_valid && !halt) begin
      pc_d = redir_pc;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (halt) begin
          if (imem_req_ready) begin
            state_d     = S_WAIT;
            drop_d      = 1'b1;
            halt_pend_d = 1'b1;
          end else begin
            state_d = S_HALTED;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end

      S_WAIT: begin
        drop_now = drop_q || redirect_valid || halt;
        halt_now = halt_pend_q || halt;
        if (imem_rsp_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = pc_q;
          if (drop_now) begin
            drop_d      = 1'b0;
            halt_pend_d = 1'b0;
            state_d     = halt_now ? S_HALTED : S_REQ;
          end else begin
            state_d = S_OUT;
          end
        end else begin
          drop_d      = drop_now;
          halt_pend_d = halt_now;
        end
      end

      S_OUT: begin
        // A same-cycle handshake always counts, even when leaving for halt/redirect.
        if (inst_ready) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!redirect_valid || halt) begin
            pc_d = pc_q + 32'd4;
          end
        end
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect_valid || inst_ready) begin
          state_d = S_REQ;
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst_pc        = inst_pc_q;
  assign inst           = inst_q;
  assign halted         = (state_q == S_HALTED);
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with a one-cycle-latency IMEM model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_cnt;

  int          checkCount;
  int          failCount;
  logic        holdRsp;
  logic        rspPending;
  logic [31:0] rspAddr;

  ifu_fetch #(
    .RESET_PC(32'h8000_0000),
    .CNT_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst          (inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a simple function of the address.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return {addr[15:0], 16'h0093};
  endfunction

  // Memory model: responds in the cycle after acceptance unless held back.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rspPending     = 1'b0;
    rspAddr        = 32'h0;
    forever begin
      @(negedge clk);
      if (rspPending && !holdRsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memData(rspAddr);
        rspPending     = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        rspPending = 1'b1;
        rspAddr    = imem_req_addr;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic reqReady, input logic instReady,
                               input logic redirValid, input logic [31:0] redirPc,
                               input logic haltIn);
    imem_req_ready = reqReady;
    inst_ready     = instReady;
    redirect_valid = redirValid;
    redirect_pc    = redirPc;
    halt           = haltIn;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input string tag, input logic [31:0] expAddr);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_valid"}, {31'h0, imem_req_valid}, 32'h1);
    checkOutput({tag, "_addr"}, imem_req_addr, expAddr);
  endtask

  task automatic waitInst(input string tag, input logic [31:0] expPc, input logic [31:0] expInst);
    int n = 0;
    while (!inst_valid && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    checkOutput({tag, "_pc"}, inst_pc, expPc);
    checkOutput({tag, "_inst"}, inst, expInst);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_reqv"}, {31'h0, imem_req_valid}, 32'h0);
    checkOutput({tag, "_addr"}, imem_req_addr, 32'h8000_0000);
    checkOutput({tag, "_instv"}, {31'h0, inst_valid}, 32'h0);
    checkOutput({tag, "_halted"}, {31'h0, halted}, 32'h0);
    checkOutput({tag, "_cnt"}, fetch_cnt, 32'h0);
    checkOutput({tag, "_inst"}, inst, 32'h0);
    checkOutput({tag, "_instpc"}, inst_pc, 32'h0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    holdRsp    = 1'b0;
    rst        = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    nextCycle();
    nextCycle();
    checkResetOutputs("rst0");

    // Basic fetch after reset release.
    rst = 1'b1;
    nextCycle();
    checkOutput("t1_req_v", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t1_req_addr", imem_req_addr, 32'h8000_0000);
    nextCycle();
    nextCycle();
    checkOutput("t1_inst_v", {31'h0, inst_valid}, 32'h1);
    checkOutput("t1_inst_pc", inst_pc, 32'h8000_0000);
    checkOutput("t1_inst", inst, 32'h0000_0093);
    inst_ready = 1'b1;
    nextCycle();
    inst_ready = 1'b0;
    checkOutput("t1_next_addr", imem_req_addr, 32'h8000_0004);
    checkOutput("t1_next_v", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t1_cnt", fetch_cnt, 32'd1);

    // Downstream backpressure holds the instruction and stalls fetch.
    waitInst("t2", 32'h8000_0004, 32'h0004_0093);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("t2_hold_v", {31'h0, inst_valid}, 32'h1);
      checkOutput("t2_hold_pc", inst_pc, 32'h8000_0004);
      checkOutput("t2_hold_inst", inst, 32'h0004_0093);
      checkOutput("t2_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    inst_ready = 1'b1;
    nextCycle();
    inst_ready = 1'b0;
    checkOutput("t2_cnt", fetch_cnt, 32'd2);
    checkOutput("t2_next_addr", imem_req_addr, 32'h8000_0008);
    holdRsp = 1'b1;

    // Redirect while waiting discards the in-flight response.
    nextCycle();
    checkOutput("t3_wait_noreq", {31'h0, imem_req_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_0103, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    holdRsp = 1'b0;
    checkOutput("t3_still_wait", {31'h0, imem_req_valid}, 32'h0);
    nextCycle();
    checkOutput("t3_dropped", {31'h0, inst_valid}, 32'h0);
    checkOutput("t3_req_v", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t3_req_addr", imem_req_addr, 32'h8000_0100);
    waitInst("t3", 32'h8000_0100, 32'h0100_0093);

    // Redirect together with a handshake still counts the transfer.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_cnt", fetch_cnt, 32'd3);
    checkOutput("t4_req_v", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t4_req_addr", imem_req_addr, 32'h8000_0200);
    waitInst("t4", 32'h8000_0200, 32'h0200_0093);

    // Halt during WAIT: response swallowed, unit goes idle.
    inst_ready = 1'b1;
    nextCycle();
    inst_ready = 1'b0;
    checkOutput("t5_cnt", fetch_cnt, 32'd4);
    checkOutput("t5_req_addr", imem_req_addr, 32'h8000_0204);
    holdRsp = 1'b1;
    nextCycle();
    halt = 1'b1;
    nextCycle();
    halt    = 1'b0;
    holdRsp = 1'b0;
    checkOutput("t5_not_yet", {31'h0, halted}, 32'h0);
    nextCycle();
    checkOutput("t5_halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      checkOutput("t5_no_req", {31'h0, imem_req_valid}, 32'h0);
      checkOutput("t5_no_inst", {31'h0, inst_valid}, 32'h0);
      checkOutput("t5_stay", {31'h0, halted}, 32'h1);
    end
    checkOutput("t5_cnt_end", fetch_cnt, 32'd4);

    // Reset exits HALTED; then exercise PC wrap and reset mid-WAIT.
    #1;
    rst = 1'b0;
    #1;
    checkResetOutputs("t6_rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    nextCycle();
    rst = 1'b1;
    waitReq("t6_req", 32'h8000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_redir_v", {31'h0, imem_req_valid}, 32'h1);
    checkOutput("t6_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    waitInst("t6_top", 32'hFFFF_FFFC, 32'hFFFC_0093);
    inst_ready = 1'b1;
    nextCycle();
    inst_ready = 1'b0;
    checkOutput("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    checkOutput("t6_wrap_cnt", fetch_cnt, 32'd1);
    holdRsp = 1'b1;
    nextCycle();
    checkOutput("t6_in_wait", {31'h0, imem_req_valid}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs("t6_async");
    holdRsp = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    rst = 1'b1;
    waitReq("t6_restart", 32'h8000_0000);
    waitInst("t6_restart", 32'h8000_0000, 32'h0000_0093);
    checkOutput("t6_restart_cnt", fetch_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Multi-cycle instruction fetch unit. It replaces the free-running PC-plus-combinational-IMEM path with a valid/ready request/response interface to instruction memory. It delivers {pc, instruction} pairs downstream to control_unit/ALU/ebreak logic through a valid/ready handshake. It owns the architectural fetch PC and supports redirect (jump/branch target) and halt (ebreak).

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset release
CNT_W, 32, width of delivered-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address, word aligned
imem_rsp_valid  input  1  response valid, one cycle per accepted request
imem_rsp_data  input  32  fetched instruction
inst_valid  output  1  instruction available downstream
inst_ready  input  1  downstream consumes instruction
inst_pc  output  32  PC of delivered instruction
inst  output  32  delivered instruction
redirect_valid  input  1  load new fetch PC
redirect_pc  input  32  new fetch PC; bits [1:0] ignored, forced 0
halt  input  1  stop fetching (ebreak)
halted  output  1  unit idle in HALTED
fetch_cnt  output  CNT_W  count of completed inst handshakes, wraps

Behaviour:
- Async reset (rst low): state=IDLE, pc_q=RESET_PC, drop=0, inst/inst_pc=0, fetch_cnt=0. All outputs 0 except imem_req_addr=RESET_PC.
- At most one outstanding memory request. No new request until the response returns.
- States and transitions:
  - IDLE: first clk after reset release goes to REQ. Fixed 1-cycle latency.
  - REQ: imem_req_valid=1, imem_req_addr=pc_q. On imem_req_valid&&imem_req_ready, go to WAIT.
  - WAIT: on imem_rsp_valid, capture rsp_data into inst and pc_q into inst_pc. If drop=0, go to OUT. If drop=1, clear drop and go to REQ (or HALTED if halt is pending).
  - OUT: inst_valid=1, inst/inst_pc held stable. On inst_valid&&inst_ready: pc_q<=pc_q+4, fetch_cnt++, go to REQ.
  - HALTED: all valids 0, halted=1. Only reset exits.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, OUT) with zero-latency memory.
- pc_q+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- imem_req_addr changes while imem_req_valid=1 only because of redirect. Memory must tolerate this.
- Redirect, by state (pc_q<={redirect_pc[31:2],2'b00} in every state):
  - REQ, not accepted: stay in REQ. New address drives from the next cycle.
  - REQ, handshake fires the same cycle: go to WAIT with drop=1.
  - WAIT: set drop=1. If the response arrives the same cycle, discard it and go to REQ.
  - OUT without handshake: inst_valid drops next cycle, go to REQ.
  - OUT with inst handshake the same cycle: the transfer counts (fetch_cnt++). pc_q takes redirect_pc, not +4. Go to REQ.
- Halt has priority over redirect. It is sampled every cycle.
  - In REQ not accepted: go to HALTED.
  - In REQ accepted, or in WAIT: set halt pending and drop=1. Wait for the response, discard it, go to HALTED.
  - In OUT: inst_valid deasserts, go to HALTED. A same-cycle handshake still counts.
- imem_rsp_valid outside WAIT is ignored (protocol error, no state change).
- Reset mid-transaction: state is abandoned immediately. A late response after reset arrives in IDLE/REQ and is ignored.
- fetch_cnt wraps at 2^CNT_W.

Test Plan:
1. Reset release with ready=1 and rsp one cycle later (data 32'h00000093) → req addr 80000000. inst_valid with inst_pc=80000000, inst=00000093 in cycle 3. Next req addr 80000004. fetch_cnt=1.
2. inst_ready=0 for 5 cycles in OUT → inst/inst_pc stable, no new imem_req_valid. Then ready=1 → one handshake, next addr +4.
3. Redirect to 32'h80000103 during WAIT → returned data discarded (inst_valid never asserts for it). Next req addr 80000100.
4. Redirect during OUT together with inst_ready=1 → fetch_cnt increments. Next req addr equals redirect target, not pc+4.
5. halt in WAIT → response consumed and dropped, halted=1, no further imem_req_valid for 20 cycles.
6. redirect_pc=FFFFFFFC then accept → next addr 00000000. Assert rst low mid-WAIT → outputs at reset values asynchronously, restart at RESET_PC.
